mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage of the RV32 core, sitting between the execute stage and writeback. It consumes the execute stage's registered outputs (ALU result, instruction word, PC, store data, writeback target) and performs RV32I loads and stores over a ready-handshaked data-memory port. It stalls upstream while a memory access is outstanding and produces the MEM-stage forwarding tap. Non-memory instructions pass through with one cycle of latency.

## Interface
- `TIMEOUT`, 255: maximum BUSY cycles waiting for `dmem_ready` before the access is aborted (1..65535).
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `alu_in` in 32: ALU result; this is the effective address for loads and stores.
- `iw_in`, `pc_in` in 32 each: instruction word and PC from execute.
- `rs2_data_in` in 32: store data.
- `wb_reg_in` in 5: destination register.
- `wb_en_in` in 1: execute stage requests a register write.
- `w_en_in` in 1: instruction is a store.
- `dmem_req` out 1: memory request valid.
- `dmem_we` out 1: 1 for a store, 0 for a load.
- `dmem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_ready` in 1: memory completes the request this cycle.
- `dmem_rdata` in 32: read word, valid when `dmem_ready`=1.
- `mem_out` out 32: writeback value.
- `iw_out`, `pc_out` out 32 each: instruction word and PC forwarded to writeback.
- `wb_reg_out` out 5: destination register to writeback.
- `wb_en_out` out 1: writeback enable.
- `stall_out` out 1: upstream must hold its outputs this cycle.
- `mem_fault` out 1: one-cycle pulse on a misaligned access, illegal funct3, or timeout.
- `df_mem_enable` out 1, `df_mem_reg` out 5, `df_mem_data` out 32: forwarding tap, equal to `wb_en_out`, `wb_reg_out`, `mem_out` (combinational copies).

## Operation
- Classification by `iw_in[6:0]`:
  - Load: opcode 0000011.
  - Store: `w_en_in`=1 (opcode 0100011).
  - Everything else is pass-through.
- Size is taken from funct3 `iw_in[14:12]`.
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
  - Any other funct3 is illegal.
- Misaligned access: H with `addr[0]`=1, or W with `addr[1:0]`≠0.
- FSM states: IDLE, BUSY.
- IDLE, pass-through input:
  - Next edge registers `mem_out`=`alu_in` and copies `iw_out`, `pc_out`, `wb_reg_out`.
  - `wb_en_out` = `wb_en_in` && `wb_reg_in`≠0.
  - `stall_out`=0.
- IDLE, legal and aligned memory op:
  - `stall_out`=1 (combinational).
  - Latch the op: address, funct3, store data, `iw`, `pc`, `rd`.
  - Next state BUSY; the output register takes a bubble (`wb_en_out`=0).
- IDLE, illegal or misaligned memory op:
  - No request is issued; `stall_out`=0.
  - Next cycle: bubble (`wb_en_out`=0) and `mem_fault`=1.
- BUSY:
  - `dmem_req`=1, with `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata` taken from the latched op and held stable.
  - `stall_out` = !`dmem_ready`.
  - Wait counter increments on each BUSY cycle without `dmem_ready`.
- BUSY with `dmem_ready`=1:
  - Next edge registers the result; state returns to IDLE. Upstream advances on the same edge.
  - Load: `mem_out` = extracted value, `wb_en_out` = rd≠0.
  - Store: `wb_en_out`=0, `mem_out`=address.
- BUSY timeout (counter reaches `TIMEOUT` with no ready):
  - `stall_out`=0 in that cycle.
  - Next edge: IDLE, `mem_fault` pulse, bubble. A late `dmem_ready` is ignored.
- Store lanes (`o` = `addr[1:0]`):
  - SB: `wdata` = `{4{rs2[7:0]}}`, `be` = 4'b0001<<o.
  - SH: `wdata` = `{2{rs2[15:0]}}`, `be` = `o[1]` ? 1100 : 0011.
  - SW: `be`=1111.
- Load extraction:
  - Byte = `rdata[8*o+:8]`; half = `rdata[16*o[1]+:16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW uses the word unchanged.

## Timing
- Pass-through latency: 1 cycle.
- Memory op latency: 1 + (BUSY cycles), minimum 2 when `dmem_ready` is high in the first BUSY cycle.
- `dmem_req` is never asserted in IDLE. It deasserts on the edge after ready or timeout; there are no back-to-back requests without an intervening IDLE cycle.
- Inputs are sampled only in IDLE. Upstream must hold them while `stall_out`=1.
- `mem_fault` is high for exactly one cycle per faulting op.
- Reset (synchronous, any state including BUSY):
  - Next cycle: state IDLE, wait counter 0.
  - All outputs 0: `dmem_req`, `dmem_we`, `dmem_be`, `dmem_addr`, `dmem_wdata`, `mem_out`, `iw_out`, `pc_out`, `wb_reg_out`, `wb_en_out`, `mem_fault`, `df_mem_*`.
  - `stall_out` reflects the IDLE rule.
- x0 is never a writeback target: `wb_en_out` is forced 0 when rd=0.

## Test plan
- ADD result passthrough: `alu_in`=0x1234, rd=5, `wb_en_in`=1 → next cycle `mem_out`=0x1234, `wb_en_out`=1, `df_mem_reg`=5; `stall_out` never asserted.
- LB at 0x103, `dmem_ready` high in the first BUSY cycle, `rdata`=0x80FF_FF00 → `dmem_addr`=0x100, `stall_out` high for 1 cycle, `mem_out`=0xFFFF_FF80, rd written.
- SH at 0x202, `rs2`=0xABCD_1234, ready after 3 wait cycles → `dmem_be`=1100, `dmem_wdata`=0x1234_1234, `dmem_we`=1, inputs held for 4 stall cycles, `wb_en_out`=0.
- LW at 0x301 → no `dmem_req`, `mem_fault` pulse, `wb_en_out`=0, no stall; funct3=011 load gives the same response.
- `TIMEOUT`=4, LHU with `dmem_ready` tied low → `dmem_req` high for 4 cycles, then `mem_fault` pulse and IDLE; a subsequent ADD passes normally.
- Reset asserted in the 2nd BUSY cycle → next cycle `dmem_req`=0 and all outputs 0; the next LW at 0x400 with ready gives `mem_out`=`rdata`.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage between execute and writeback.
// One ready-handshaked data-memory access is outstanding at a time. Upstream
// is stalled while it is in flight, and non-memory instructions pass through
// with one cycle of latency. A misaligned access, an illegal funct3 or a
// timeout retires as a bubble with a one-cycle mem_fault pulse.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_in,
  input  logic [31:0] iw_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] rs2_data_in,
  input  logic [4:0]  wb_reg_in,
  input  logic        wb_en_in,
  input  logic        w_en_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_out,
  output logic [31:0] iw_out,
  output logic [31:0] pc_out,
  output logic [4:0]  wb_reg_out,
  output logic        wb_en_out,
  output logic        stall_out,
  output logic        mem_fault,
  output logic        df_mem_enable,
  output logic [4:0]  df_mem_reg,
  output logic [31:0] df_mem_data
);
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q;
  logic [15:0] wait_q;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic [31:0] rs2_q;
  logic [31:0] iw_q;
  logic [31:0] pc_q;
  logic [4:0]  rd_q;
  logic        store_q;
  logic [31:0] mem_out_q;
  logic [31:0] iw_out_q;
  logic [31:0] pc_out_q;
  logic [4:0]  wb_reg_q;
  logic        wb_en_q;
  logic        fault_q;

  logic [2:0]  f3_in;
  logic        is_store_in;
  logic        is_load_in;
  logic        mem_op_in;
  logic        legal_in;
  logic        misalign_in;
  logic        accept_in;
  logic        busy;
  logic        timeout_hit;

  // Byte enables for the access size at byte offset o.
  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] o);
    case (f3[1:0])
      2'b00:   lane_be = 4'b0001 << o;
      2'b01:   lane_be = o[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Replicate store data across all lanes so the byte enables select it.
  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   lane_wdata = {4{d[7:0]}};
      2'b01:   lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] o,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{o, 3'b000} +: 8];
    h = w[{o[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b100:  load_extract = {24'd0, b};
      3'b101:  load_extract = {16'd0, h};
      default: load_extract = w;
    endcase
  endfunction

  // Classify the incoming instruction and check funct3 legality and alignment.
  always_comb begin
    f3_in       = iw_in[14:12];
    is_store_in = w_en_in;
    is_load_in  = !w_en_in && (iw_in[6:0] == OP_LOAD);
    mem_op_in   = is_store_in || is_load_in;
    if (is_store_in) legal_in = (f3_in == 3'b000) || (f3_in == 3'b001) || (f3_in == 3'b010);
    else             legal_in = (f3_in == 3'b000) || (f3_in == 3'b001) || (f3_in == 3'b010) ||
                                (f3_in == 3'b100) || (f3_in == 3'b101);
    case (f3_in[1:0])
      2'b01:   misalign_in = alu_in[0];
      2'b10:   misalign_in = (alu_in[1:0] != 2'b00);
      default: misalign_in = 1'b0;
    endcase
    accept_in = mem_op_in && legal_in && !misalign_in;
  end

  assign busy        = (state_q == BUSY);
  assign timeout_hit = busy && !dmem_ready && (wait_q == WAIT_LAST);
  // Stall while a legal op is being accepted or an access is still waiting.
  assign stall_out   = busy ? (!dmem_ready && !timeout_hit) : accept_in;

  assign dmem_req   = busy;
  assign dmem_we    = busy && store_q;
  assign dmem_addr  = busy ? {addr_q[31:2], 2'b00} : 32'd0;
  assign dmem_be    = busy ? lane_be(f3_q, addr_q[1:0]) : 4'd0;
  assign dmem_wdata = (busy && store_q) ? lane_wdata(f3_q, rs2_q) : 32'd0;

  assign mem_out       = mem_out_q;
  assign iw_out        = iw_out_q;
  assign pc_out        = pc_out_q;
  assign wb_reg_out    = wb_reg_q;
  assign wb_en_out     = wb_en_q;
  assign mem_fault     = fault_q;
  assign df_mem_enable = wb_en_q;
  assign df_mem_reg    = wb_reg_q;
  assign df_mem_data   = mem_out_q;

  // IDLE/BUSY access FSM together with the latched op and the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wait_q    <= 16'd0;
      addr_q    <= 32'd0;
      f3_q      <= 3'd0;
      rs2_q     <= 32'd0;
      iw_q      <= 32'd0;
      pc_q      <= 32'd0;
      rd_q      <= 5'd0;
      store_q   <= 1'b0;
      mem_out_q <= 32'd0;
      iw_out_q  <= 32'd0;
      pc_out_q  <= 32'd0;
      wb_reg_q  <= 5'd0;
      wb_en_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!mem_op_in) begin
            mem_out_q <= alu_in;
            iw_out_q  <= iw_in;
            pc_out_q  <= pc_in;
            wb_reg_q  <= wb_reg_in;
            wb_en_q   <= wb_en_in && (wb_reg_in != 5'd0);
          end else if (accept_in) begin
            addr_q  <= alu_in;
            f3_q    <= f3_in;
            rs2_q   <= rs2_data_in;
            iw_q    <= iw_in;
            pc_q    <= pc_in;
            rd_q    <= wb_reg_in;
            store_q <= is_store_in;
            wait_q  <= 16'd0;
            wb_en_q <= 1'b0;
            state_q <= BUSY;
          end else begin
            wb_en_q <= 1'b0;
            fault_q <= 1'b1;
          end
        end
        BUSY: begin
          if (dmem_ready) begin
            mem_out_q <= store_q ? addr_q : load_extract(f3_q, addr_q[1:0], dmem_rdata);
            iw_out_q  <= iw_q;
            pc_out_q  <= pc_q;
            wb_reg_q  <= rd_q;
            wb_en_q   <= !store_q && (rd_q != 5'd0);
            state_q   <= IDLE;
          end else if (timeout_hit) begin
            wb_en_q <= 1'b0;
            fault_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: scenario tasks with a queue of expected retirements.
module tb_mem_stage;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_in, iw_in, pc_in, rs2_data_in;
  logic [4:0]  wb_reg_in;
  logic        wb_en_in, w_en_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] mem_out, iw_out, pc_out;
  logic [4:0]  wb_reg_out;
  logic        wb_en_out, stall_out, mem_fault;
  logic        df_mem_enable;
  logic [4:0]  df_mem_reg;
  logic [31:0] df_mem_data;

  typedef struct {
    logic [31:0] data;
    logic        en;
    logic [4:0]  rd;
    logic        fault;
  } exp_t;
  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .alu_in(alu_in), .iw_in(iw_in), .pc_in(pc_in), .rs2_data_in(rs2_data_in),
    .wb_reg_in(wb_reg_in), .wb_en_in(wb_en_in), .w_en_in(w_en_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_out(mem_out), .iw_out(iw_out), .pc_out(pc_out), .wb_reg_out(wb_reg_out),
    .wb_en_out(wb_en_out), .stall_out(stall_out), .mem_fault(mem_fault),
    .df_mem_enable(df_mem_enable), .df_mem_reg(df_mem_reg), .df_mem_data(df_mem_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=still_running exp=finished");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mk_iw(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
    return {17'd0, f3, rd, op};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] iw, input logic [31:0] pc,
                       input logic [31:0] rs2, input logic [4:0] rd, input logic wben, input logic wen);
    alu_in = alu; iw_in = iw; pc_in = pc; rs2_data_in = rs2;
    wb_reg_in = rd; wb_en_in = wben; w_en_in = wen;
  endtask

  task automatic nop();
    drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; nop(); dmem_ready = 1'b0; dmem_rdata = 32'd0;
    step(); step();
    checks++;
    if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, mem_out, iw_out, pc_out, wb_reg_out,
         wb_en_out, mem_fault, df_mem_enable, df_mem_reg, df_mem_data} !== '0) begin
      failures++; $display("FAIL reset_outputs got_mem_out=%h got_req=%b got_wb_en=%b exp=all_zero", mem_out, dmem_req, wb_en_out);
    end
    reset = 1'b0;
    #1;
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_out); end
  endtask

  task automatic test_passthrough();
    exp_t e;
    drive(32'h1234, mk_iw(OP_ALU, 3'b000, 5'd5), 32'h40, 32'h0, 5'd5, 1'b1, 1'b0);
    #1;
    checks++; if (stall_out !== 1'b0 || dmem_req !== 1'b0) begin failures++; $display("FAIL add_stall got=%b/%b exp=0/0", stall_out, dmem_req); end
    sb.push_back('{32'h1234, 1'b1, 5'd5, 1'b0});
    step();
    // back-to-back ADD targeting x0: must never enable writeback
    drive(32'h5555, mk_iw(OP_ALU, 3'b000, 5'd0), 32'h44, 32'h0, 5'd0, 1'b1, 1'b0);
    sb.push_back('{32'h5555, 1'b0, 5'd0, 1'b0});
    e = sb.pop_front();
    checks++; if (mem_out !== e.data) begin failures++; $display("FAIL add_mem_out got=%h exp=%h", mem_out, e.data); end
    checks++; if (wb_en_out !== e.en || df_mem_enable !== e.en) begin failures++; $display("FAIL add_wb_en got=%b exp=%b", wb_en_out, e.en); end
    checks++; if (df_mem_reg !== e.rd || df_mem_data !== e.data) begin failures++; $display("FAIL add_df got=%0d/%h exp=%0d/%h", df_mem_reg, df_mem_data, e.rd, e.data); end
    checks++; if (pc_out !== 32'h40 || iw_out !== mk_iw(OP_ALU, 3'b000, 5'd5)) begin failures++; $display("FAIL add_pc_iw got=%h/%h exp=%h/%h", pc_out, iw_out, 32'h40, mk_iw(OP_ALU, 3'b000, 5'd5)); end
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL add2_stall got=%b exp=0", stall_out); end
    step();
    nop();
    e = sb.pop_front();
    checks++; if (mem_out !== e.data || wb_en_out !== e.en) begin failures++; $display("FAIL x0_wb_en got=%h/%b exp=%h/%b", mem_out, wb_en_out, e.data, e.en); end
  endtask

  task automatic test_lb();
    exp_t e;
    drive(32'h103, mk_iw(OP_LOAD, 3'b000, 5'd7), 32'h80, 32'h0, 5'd7, 1'b1, 1'b0);
    #1;
    checks++; if (stall_out !== 1'b1 || dmem_req !== 1'b0) begin failures++; $display("FAIL lb_idle got=%b/%b exp=1/0", stall_out, dmem_req); end
    sb.push_back('{32'hFFFF_FF80, 1'b1, 5'd7, 1'b0});
    step();
    dmem_ready = 1'b1; dmem_rdata = 32'h80FF_FF00;
    #1;
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100) begin failures++; $display("FAIL lb_bus got=%b/%b/%h exp=1/0/00000100", dmem_req, dmem_we, dmem_addr); end
    checks++; if (stall_out !== 1'b0 || wb_en_out !== 1'b0) begin failures++; $display("FAIL lb_busy got=%b/%b exp=0/0", stall_out, wb_en_out); end
    step();
    dmem_ready = 1'b0; nop();
    #1;
    e = sb.pop_front();
    checks++; if (mem_out !== e.data) begin failures++; $display("FAIL lb_data got=%h exp=%h", mem_out, e.data); end
    checks++; if (wb_en_out !== e.en || wb_reg_out !== e.rd || mem_fault !== e.fault) begin failures++; $display("FAIL lb_wb got=%b/%0d/%b exp=%b/%0d/%b", wb_en_out, wb_reg_out, mem_fault, e.en, e.rd, e.fault); end
    checks++; if (dmem_req !== 1'b0 || pc_out !== 32'h80) begin failures++; $display("FAIL lb_after got=%b/%h exp=0/00000080", dmem_req, pc_out); end
  endtask

  task automatic test_store();
    exp_t e;
    int   stalls;
    stalls = 0;
    drive(32'h202, mk_iw(OP_STORE, 3'b001, 5'd0), 32'hC0, 32'hABCD_1234, 5'd0, 1'b0, 1'b1);
    #1;
    if (stall_out === 1'b1) stalls++;
    sb.push_back('{32'h202, 1'b0, 5'd0, 1'b0});
    for (int i = 0; i < 4; i++) begin
      step();
      dmem_ready = (i == 3);
      #1;
      checks++;
      if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 4'b1100, 32'h200, 32'h1234_1234}) begin
        failures++; $display("FAIL sh_bus cyc=%0d got=%b/%b/%b/%h/%h exp=1/1/1100/00000200/12341234", i, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata);
      end
      if (stall_out === 1'b1) stalls++;
    end
    checks++; if (stalls !== 4) begin failures++; $display("FAIL sh_stall_cycles got=%0d exp=4", stalls); end
    step();
    dmem_ready = 1'b0;
    // SB at offset 1 issued right after, ready in the first BUSY cycle
    drive(32'h201, mk_iw(OP_STORE, 3'b000, 5'd0), 32'hC4, 32'h0000_0034, 5'd0, 1'b0, 1'b1);
    e = sb.pop_front();
    checks++; if (mem_out !== e.data || wb_en_out !== e.en || mem_fault !== e.fault) begin failures++; $display("FAIL sh_result got=%h/%b/%b exp=%h/%b/%b", mem_out, wb_en_out, mem_fault, e.data, e.en, e.fault); end
    sb.push_back('{32'h201, 1'b0, 5'd0, 1'b0});
    step();
    dmem_ready = 1'b1;
    #1;
    checks++; if ({dmem_be, dmem_wdata, dmem_addr} !== {4'b0010, 32'h3434_3434, 32'h200}) begin failures++; $display("FAIL sb_bus got=%b/%h/%h exp=0010/34343434/00000200", dmem_be, dmem_wdata, dmem_addr); end
    step();
    dmem_ready = 1'b0; nop();
    e = sb.pop_front();
    checks++; if (mem_out !== e.data || wb_en_out !== e.en) begin failures++; $display("FAIL sb_result got=%h/%b exp=%h/%b", mem_out, wb_en_out, e.data, e.en); end
  endtask

  task automatic test_fault();
    exp_t        e;
    logic [31:0] a[3];
    logic [31:0] iw[3];
    logic        st[3];
    a[0] = 32'h301; iw[0] = mk_iw(OP_LOAD, 3'b010, 5'd6);  st[0] = 1'b0;
    a[1] = 32'h300; iw[1] = mk_iw(OP_LOAD, 3'b011, 5'd6);  st[1] = 1'b0;
    a[2] = 32'h206; iw[2] = mk_iw(OP_STORE, 3'b010, 5'd0); st[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(a[i], iw[i], 32'h100, 32'h0, st[i] ? 5'd0 : 5'd6, !st[i], st[i]);
      #1;
      checks++; if (stall_out !== 1'b0 || dmem_req !== 1'b0) begin failures++; $display("FAIL fault%0d_issue got=%b/%b exp=0/0", i, stall_out, dmem_req); end
      sb.push_back('{32'h0, 1'b0, 5'd0, 1'b1});
      step();
      nop();
      #1;
      e = sb.pop_front();
      checks++; if (mem_fault !== e.fault || wb_en_out !== e.en || dmem_req !== 1'b0) begin failures++; $display("FAIL fault%0d_pulse got=%b/%b/%b exp=%b/%b/0", i, mem_fault, wb_en_out, dmem_req, e.fault, e.en); end
      step();
      checks++; if (mem_fault !== 1'b0) begin failures++; $display("FAIL fault%0d_width got=%b exp=0", i, mem_fault); end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int   reqs;
    reqs = 0;
    drive(32'h502, mk_iw(OP_LOAD, 3'b101, 5'd9), 32'h140, 32'h0, 5'd9, 1'b1, 1'b0);
    #1;
    checks++; if (stall_out !== 1'b1) begin failures++; $display("FAIL to_idle_stall got=%b exp=1", stall_out); end
    sb.push_back('{32'h0, 1'b0, 5'd0, 1'b1});
    for (int i = 0; i < 4; i++) begin
      step();
      if (dmem_req === 1'b1) reqs++;
      checks++; if (stall_out !== (i < 3)) begin failures++; $display("FAIL to_stall cyc=%0d got=%b exp=%b", i, stall_out, (i < 3)); end
    end
    step();
    nop();
    #1;
    if (dmem_req === 1'b1) reqs++;
    checks++; if (reqs !== 4) begin failures++; $display("FAIL to_req_cycles got=%0d exp=4", reqs); end
    e = sb.pop_front();
    checks++; if (mem_fault !== e.fault || wb_en_out !== e.en) begin failures++; $display("FAIL to_fault got=%b/%b exp=%b/%b", mem_fault, wb_en_out, e.fault, e.en); end
    dmem_ready = 1'b1;
    step();
    checks++; if (mem_fault !== 1'b0 || dmem_req !== 1'b0 || stall_out !== 1'b0) begin failures++; $display("FAIL to_late_ready got=%b/%b/%b exp=0/0/0", mem_fault, dmem_req, stall_out); end
    dmem_ready = 1'b0;
    drive(32'h77, mk_iw(OP_ALU, 3'b000, 5'd3), 32'h148, 32'h0, 5'd3, 1'b1, 1'b0);
    sb.push_back('{32'h77, 1'b1, 5'd3, 1'b0});
    step();
    nop();
    e = sb.pop_front();
    checks++; if (mem_out !== e.data || wb_en_out !== e.en || wb_reg_out !== e.rd) begin failures++; $display("FAIL to_add_after got=%h/%b/%0d exp=%h/%b/%0d", mem_out, wb_en_out, wb_reg_out, e.data, e.en, e.rd); end
  endtask

  task automatic test_reset_busy();
    exp_t e;
    drive(32'h400, mk_iw(OP_LOAD, 3'b010, 5'd4), 32'h200, 32'h0, 5'd4, 1'b1, 1'b0);
    step();
    checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL rb_busy1 got=%b exp=1", dmem_req); end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; nop();
    #1;
    checks++;
    if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, mem_out, iw_out, pc_out, wb_reg_out,
         wb_en_out, mem_fault, df_mem_enable, df_mem_reg, df_mem_data, stall_out} !== '0) begin
      failures++; $display("FAIL rb_outputs got_req=%b got_mem_out=%h got_pc=%h got_stall=%b exp=all_zero", dmem_req, mem_out, pc_out, stall_out);
    end
    drive(32'h400, mk_iw(OP_LOAD, 3'b010, 5'd4), 32'h210, 32'h0, 5'd4, 1'b1, 1'b0);
    sb.push_back('{32'hDEAD_BEEF, 1'b1, 5'd4, 1'b0});
    step();
    dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    step();
    dmem_ready = 1'b0; nop();
    e = sb.pop_front();
    checks++; if (mem_out !== e.data || wb_en_out !== e.en || wb_reg_out !== e.rd) begin failures++; $display("FAIL rb_lw got=%h/%b/%0d exp=%h/%b/%0d", mem_out, wb_en_out, wb_reg_out, e.data, e.en, e.rd); end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic [31:0] res;
  } ld_t;

  task automatic test_back_to_back();
    exp_t e;
    ld_t  t[5];
    t[0] = '{32'h102, 3'b001, 32'h8001_0000, 32'hFFFF_8001};
    t[1] = '{32'h102, 3'b101, 32'h8001_0000, 32'h0000_8001};
    t[2] = '{32'h101, 3'b100, 32'h0000_9000, 32'h0000_0090};
    t[3] = '{32'h100, 3'b000, 32'h0000_007F, 32'h0000_007F};
    t[4] = '{32'h10C, 3'b010, 32'h1234_5678, 32'h1234_5678};
    for (int i = 0; i < 5; i++) begin
      drive(t[i].a, mk_iw(OP_LOAD, t[i].f3, 5'd10), 32'h300, 32'h0, 5'd10, 1'b1, 1'b0);
      #1;
      checks++; if (dmem_req !== 1'b0 || stall_out !== 1'b1) begin failures++; $display("FAIL b2b%0d_idle got=%b/%b exp=0/1", i, dmem_req, stall_out); end
      sb.push_back('{t[i].res, 1'b1, 5'd10, 1'b0});
      step();
      dmem_ready = 1'b1; dmem_rdata = t[i].rdata;
      #1;
      checks++; if (dmem_req !== 1'b1 || dmem_addr !== {t[i].a[31:2], 2'b00}) begin failures++; $display("FAIL b2b%0d_bus got=%b/%h exp=1/%h", i, dmem_req, dmem_addr, {t[i].a[31:2], 2'b00}); end
      step();
      dmem_ready = 1'b0;
      e = sb.pop_front();
      checks++; if (mem_out !== e.data || wb_en_out !== e.en) begin failures++; $display("FAIL b2b%0d_data got=%h/%b exp=%h/%b", i, mem_out, wb_en_out, e.data, e.en); end
    end
    nop();
  endtask

  initial begin
    reset = 1'b1; dmem_ready = 1'b0; dmem_rdata = 32'd0;
    nop();
    test_reset();
    test_passthrough();
    test_lb();
    test_store();
    test_fault();
    test_timeout();
    test_reset_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
